// File: rtl/regfile_pkg.sv
// Shared defaults for the register file with load scoreboard.
// The top register is the link register: reads return the PC link value, writes are dropped.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NREGS_DEF  = 16;
  localparam int unsigned NRP_DEF    = 3;
  localparam int unsigned LINK_REG   = NREGS_DEF - 1;

  function automatic int unsigned link_reg(input int unsigned nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register, set by accepted load issue, cleared by load
// write-back, with a registered population count and a combinational WAW issue guard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRP   = NRP_DEF,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_iss_valid,
  input  logic [AW-1:0]          i_iss_reg,
  input  logic                   i_we_b,
  input  logic [AW-1:0]          i_wa_b,
  input  logic [NRP-1:0][AW-1:0] i_ra,
  output logic                   o_iss_ready,
  output logic [NRP-1:0]         o_rd_valid,
  output logic [AW:0]            o_pend_cnt
);

  localparam logic [AW-1:0] LinkIdx = AW'(link_reg(NREGS));

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend_d;
  logic [AW:0]      r_cnt;
  logic [AW:0]      w_cnt_d;
  logic             w_iss_ready;

  assign w_iss_ready = !r_pend[i_iss_reg] || (i_we_b && (i_wa_b == i_iss_reg));

  always_comb begin
    w_pend_d = r_pend;
    if (i_we_b) begin
      w_pend_d[i_wa_b] = 1'b0;
    end
    // Applied after the clear so a same-cycle set wins.
    if (i_iss_valid && w_iss_ready && (i_iss_reg != LinkIdx)) begin
      w_pend_d[i_iss_reg] = 1'b1;
    end
    w_cnt_d = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      w_cnt_d = w_cnt_d + (AW+1)'(w_pend_d[k]);
    end
  end

  always_comb begin
    o_rd_valid = '0;
    for (int unsigned i = 0; i < NRP; i++) begin
      o_rd_valid[i] = !r_pend[i_ra[i]] || (i_we_b && (i_wa_b == i_ra[i]));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign o_iss_ready = w_iss_ready;
  assign o_pend_cnt  = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with write forwarding, a PC link register at the top
// index, and a pending-load scoreboard that qualifies read data and gates load issue.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRP    = NRP_DEF,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NRP-1:0][AW-1:0]     ra,
  output logic [NRP-1:0][DATA_W-1:0] rd,
  output logic [NRP-1:0]             rd_valid,
  input  logic                       we_a,
  input  logic [AW-1:0]              wa_a,
  input  logic [DATA_W-1:0]          wd_a,
  input  logic                       we_b,
  input  logic [AW-1:0]              wa_b,
  input  logic [DATA_W-1:0]          wd_b,
  input  logic [DATA_W-1:0]          pc_in,
  input  logic                       iss_valid,
  input  logic [AW-1:0]              iss_reg,
  output logic                       iss_ready,
  output logic [AW:0]                pend_cnt
);

  localparam logic [AW-1:0] LinkIdx = AW'(link_reg(NREGS));

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [NRP-1:0]    w_sb_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NREGS; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      // Port A is written last so it wins an address collision.
      if (we_b && (wa_b != LinkIdx)) begin
        r_mem[wa_b] <= wd_b;
      end
      if (we_a && (wa_a != LinkIdx)) begin
        r_mem[wa_a] <= wd_a;
      end
    end
  end

  always_comb begin
    rd       = '0;
    rd_valid = '0;
    for (int unsigned i = 0; i < NRP; i++) begin
      if (ra[i] == LinkIdx) begin
        rd[i] = pc_in;
      end else if (we_a && (wa_a == ra[i])) begin
        rd[i] = wd_a;
      end else if (we_b && (wa_b == ra[i])) begin
        rd[i] = wd_b;
      end else begin
        rd[i] = r_mem[ra[i]];
      end
      rd_valid[i] = (ra[i] == LinkIdx) || w_sb_valid[i];
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRP   (NRP)
  ) u_scoreboard (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_iss_valid (iss_valid),
    .i_iss_reg   (iss_reg),
    .i_we_b      (we_b),
    .i_wa_b      (wa_b),
    .i_ra        (ra),
    .o_iss_ready (iss_ready),
    .o_rd_valid  (w_sb_valid),
    .o_pend_cnt  (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: inputs change on the falling edge, outputs are sampled 1ns
// later (combinational paths) or after the following rising edge (registered state).
module tb_regfile_sb;

  localparam int unsigned DataW = 32;
  localparam int unsigned NRegs = 16;
  localparam int unsigned Nrp   = 3;
  localparam int unsigned Aw    = 4;

  logic                     clk;
  logic                     rst_n;
  logic [Nrp-1:0][Aw-1:0]   ra;
  logic [Nrp-1:0][DataW-1:0] rd;
  logic [Nrp-1:0]           rd_valid;
  logic                     we_a;
  logic [Aw-1:0]            wa_a;
  logic [DataW-1:0]         wd_a;
  logic                     we_b;
  logic [Aw-1:0]            wa_b;
  logic [DataW-1:0]         wd_b;
  logic [DataW-1:0]         pc_in;
  logic                     iss_valid;
  logic [Aw-1:0]            iss_reg;
  logic                     iss_ready;
  logic [Aw:0]              pend_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  regfile_sb #(
    .DATA_W (DataW),
    .NREGS  (NRegs),
    .NRP    (Nrp)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra        (ra),
    .rd        (rd),
    .rd_valid  (rd_valid),
    .we_a      (we_a),
    .wa_a      (wa_a),
    .wd_a      (wd_a),
    .we_b      (we_b),
    .wa_b      (wa_b),
    .wd_b      (wd_b),
    .pc_in     (pc_in),
    .iss_valid (iss_valid),
    .iss_reg   (iss_reg),
    .iss_ready (iss_ready),
    .pend_cnt  (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    we_a      = 1'b0;
    wa_a      = '0;
    wd_a      = '0;
    we_b      = 1'b0;
    wa_b      = '0;
    wd_b      = '0;
    iss_valid = 1'b0;
    iss_reg   = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    ra    = '0;
    pc_in = '0;
    idle_inputs();

    // Reset state
    #1;
    check_eq("reset_rd0", rd[0], 32'h0);
    check_eq("reset_rd_valid", {29'd0, rd_valid}, 32'h7);
    check_eq("reset_iss_ready", {31'd0, iss_ready}, 32'h1);
    check_eq("reset_pend_cnt", {27'd0, pend_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Port A write, read back next cycle
    @(negedge clk);
    we_a = 1'b1; wa_a = 4'd3; wd_a = 32'h1234;
    @(negedge clk);
    idle_inputs();
    ra[0] = 4'd3;
    #1;
    check_eq("r3_read", rd[0], 32'h0000_1234);
    check_eq("r3_valid", {31'd0, rd_valid[0]}, 32'h1);

    // Both ports hit R5: port A forwarded and stored
    @(negedge clk);
    we_a = 1'b1; wa_a = 4'd5; wd_a = 32'hAAAA;
    we_b = 1'b1; wa_b = 4'd5; wd_b = 32'h5555;
    ra[1] = 4'd5;
    #1;
    check_eq("r5_fwd", rd[1], 32'hAAAA);
    @(negedge clk);
    idle_inputs();
    #1;
    check_eq("r5_stored", rd[1], 32'hAAAA);

    // Load issue to R7, WAW guard, write-back clears
    @(negedge clk);
    iss_valid = 1'b1; iss_reg = 4'd7;
    #1;
    check_eq("iss7_ready", {31'd0, iss_ready}, 32'h1);
    @(negedge clk);
    ra[2] = 4'd7;
    #1;
    check_eq("r7_pending_valid", {31'd0, rd_valid[2]}, 32'h0);
    check_eq("r7_pend_cnt", {27'd0, pend_cnt}, 32'h1);
    check_eq("iss7_again_ready", {31'd0, iss_ready}, 32'h0);
    @(negedge clk);
    iss_valid = 1'b0;
    we_b = 1'b1; wa_b = 4'd7; wd_b = 32'hBEEF;
    #1;
    check_eq("r7_wb_fwd", rd[2], 32'hBEEF);
    check_eq("r7_wb_valid", {31'd0, rd_valid[2]}, 32'h1);
    check_eq("iss7_guard_ready", {31'd0, iss_ready}, 32'h1);
    @(negedge clk);
    idle_inputs();
    #1;
    check_eq("r7_cleared_cnt", {27'd0, pend_cnt}, 32'h0);
    check_eq("r7_stored", rd[2], 32'hBEEF);

    // Issue and write-back to R2 together: set wins
    @(negedge clk);
    iss_valid = 1'b1; iss_reg = 4'd2;
    we_b = 1'b1; wa_b = 4'd2; wd_b = 32'h2222;
    #1;
    check_eq("iss2_ready", {31'd0, iss_ready}, 32'h1);
    @(negedge clk);
    idle_inputs();
    ra[0] = 4'd2;
    #1;
    check_eq("r2_stored", rd[0], 32'h2222);
    check_eq("r2_pending", {31'd0, rd_valid[0]}, 32'h0);
    check_eq("r2_pend_cnt", {27'd0, pend_cnt}, 32'h1);
    // Already pending: guard admits the re-issue and the bit stays set
    @(negedge clk);
    iss_valid = 1'b1; iss_reg = 4'd2;
    we_b = 1'b1; wa_b = 4'd2; wd_b = 32'h3333;
    #1;
    check_eq("iss2_guard_ready", {31'd0, iss_ready}, 32'h1);
    @(negedge clk);
    idle_inputs();
    #1;
    check_eq("r2_still_pending", {31'd0, rd_valid[0]}, 32'h0);
    check_eq("r2_restored", rd[0], 32'h3333);
    check_eq("r2_pend_cnt2", {27'd0, pend_cnt}, 32'h1);

    // Link register: PC value, writes dropped, issue ignored
    @(negedge clk);
    pc_in = 32'h108;
    ra[1] = 4'd15;
    we_a = 1'b1; wa_a = 4'd15; wd_a = 32'hFFFF;
    iss_valid = 1'b1; iss_reg = 4'd15;
    #1;
    check_eq("link_before", rd[1], 32'h108);
    check_eq("link_valid", {31'd0, rd_valid[1]}, 32'h1);
    check_eq("link_iss_ready", {31'd0, iss_ready}, 32'h1);
    @(negedge clk);
    idle_inputs();
    #1;
    check_eq("link_after", rd[1], 32'h108);
    check_eq("link_pend_cnt", {27'd0, pend_cnt}, 32'h1);

    // Three pending, then asynchronous reset between edges
    @(negedge clk);
    iss_valid = 1'b1; iss_reg = 4'd8;
    @(negedge clk);
    iss_reg = 4'd9;
    @(negedge clk);
    idle_inputs();
    ra[1] = 4'd3;
    ra[2] = 4'd5;
    #1;
    check_eq("three_pending", {27'd0, pend_cnt}, 32'h3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_pend_cnt", {27'd0, pend_cnt}, 32'h0);
    check_eq("async_rd0", rd[0], 32'h0);
    check_eq("async_rd1", rd[1], 32'h0);
    check_eq("async_rd2", rd[2], 32'h0);
    check_eq("async_rd_valid", {29'd0, rd_valid}, 32'h7);
    @(negedge clk);
    rst_n = 1'b1;

    // Write-back to a register whose pending bit was dropped by reset
    we_b = 1'b1; wa_b = 4'd8; wd_b = 32'h77;
    @(negedge clk);
    idle_inputs();
    ra[0] = 4'd8;
    #1;
    check_eq("post_rst_cnt", {27'd0, pend_cnt}, 32'h0);
    check_eq("post_rst_r8", rd[0], 32'h77);
    check_eq("post_rst_valid", {31'd0, rd_valid[0]}, 32'h1);

    // Port A write does not clear a pending bit
    @(negedge clk);
    iss_valid = 1'b1; iss_reg = 4'd4;
    @(negedge clk);
    idle_inputs();
    we_a = 1'b1; wa_a = 4'd4; wd_a = 32'h44;
    @(negedge clk);
    idle_inputs();
    ra[0] = 4'd4;
    #1;
    check_eq("r4_a_data", rd[0], 32'h44);
    check_eq("r4_still_pending", {31'd0, rd_valid[0]}, 32'h0);
    check_eq("r4_pend_cnt", {27'd0, pend_cnt}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
